// File: rtl/key_debounce_if.sv
// key_debounce_if
//   Bundles the note-button signals between the button front end and the
//   conditioning stage.
//   key_raw : 7  raw button levels, asynchronous, 1 = pressed
//   key     : 7  debounced key vector, 1 = held (bit 0 = do ... bit 6 = si)
//   press   : 7  one-cycle pulse on a key 0->1 transition
//   rel     : 7  one-cycle pulse on a key 1->0 transition
//               ('release' is a reserved word, hence the short name)
//   active  : 1  any key held
//   modport master : button source side (drives key_raw)
//   modport slave  : key_debounce side (drives the conditioned outputs)
interface key_debounce_if;
   logic [6:0] key_raw;
   logic [6:0] key;
   logic [6:0] press;
   logic [6:0] rel;
   logic       active;

   modport master (output key_raw, input key, press, rel, active);
   modport slave  (input key_raw, output key, press, rel, active);
endinterface

// File: rtl/key_debounce.sv
// key_debounce
//   Synchronises the seven raw note buttons, debounces each bit with its own
//   counter and produces a clean key vector with press/release pulses.
//   Parameters:
//     DB_CYCLES : consecutive disagreeing cycles before a bit flips (>= 1)
//     CW        : per-key counter width, derived from DB_CYCLES
//   Ports:
//     clk   : system clock
//     rst_n : asynchronous active-low reset
//     bus   : key_debounce_if.slave (key_raw in; key/press/rel/active out)
//   Optional feature, macro KEY_ONEHOT_EN:
//     defined   -> single-owner arbitration, key is always 0 or one-hot,
//                  one extra cycle of latency
//     undefined -> key follows the debounced state directly (chords multi-hot)
module key_debounce #(
   parameter int unsigned DB_CYCLES = 2_000_000,
   parameter int unsigned CW        = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1
) (
   input logic            clk,
   input logic            rst_n,
   key_debounce_if.slave  bus
);

   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic [6:0]    s1;
   logic [6:0]    s2;
   logic [6:0]    stable;
   logic [6:0]    stable_d;
   logic [CW-1:0] cnt   [7];
   logic [CW-1:0] cnt_d [7];
   logic [6:0]    key_q;
   logic [6:0]    key_d;
   logic [6:0]    press_q;
   logic [6:0]    rel_q;

   // Any agreeing cycle restarts the count; the count never passes CNT_LAST
   // because reaching it flips the state and clears the counter.
   always_comb begin
      stable_d = stable;
      for (int unsigned i = 0; i < 7; i++) begin
         cnt_d[i] = '0;
         if (s2[i] != stable[i]) begin
            if (cnt[i] == CNT_LAST)
               stable_d[i] = s2[i];
            else
               cnt_d[i] = cnt[i] + 1'b1;
         end
      end
   end

`ifdef KEY_ONEHOT_EN
   // key_q acts as the owner register. Losing the owner clears it for one
   // cycle; re-arbitration among still-held keys happens on the next edge.
   always_comb begin
      if (key_q == '0)
         key_d = stable & (~stable + 7'd1);
      else if ((key_q & stable) == '0)
         key_d = '0;
      else
         key_d = key_q;
   end
`else
   // Tracks the debounced state on the same edge it flips, so no latency
   // is added; key_q always equals stable.
   assign key_d = stable_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1      <= '0;
         s2      <= '0;
         stable  <= '0;
         key_q   <= '0;
         press_q <= '0;
         rel_q   <= '0;
         for (int unsigned i = 0; i < 7; i++)
            cnt[i] <= '0;
      end else begin
         s1      <= bus.key_raw;
         s2      <= s1;
         stable  <= stable_d;
         key_q   <= key_d;
         press_q <= key_d & ~key_q;
         rel_q   <= ~key_d & key_q;
         for (int unsigned i = 0; i < 7; i++)
            cnt[i] <= cnt_d[i];
      end
   end

   assign bus.key    = key_q;
   assign bus.press  = press_q;
   assign bus.rel    = rel_q;
   assign bus.active = |key_q;

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce
//   Directed bench for key_debounce with DB_CYCLES = 4. Expected latencies
//   follow the KEY_ONEHOT_EN setting of the build.
module tb_key_debounce;

   localparam int DB = 4;
`ifdef KEY_ONEHOT_EN
   localparam int LAT = DB + 2;
   localparam bit ONEHOT = 1'b1;
`else
   localparam int LAT = DB + 1;
   localparam bit ONEHOT = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   key_debounce_if bus ();

   key_debounce #(.DB_CYCLES(DB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one active edge and settle before sampling or driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.key_raw = 7'h00;
      idle(2);
      total++;
      if ({bus.key, bus.press, bus.rel, bus.active} !== 22'h0) begin
         bad++;
         $display("FAIL reset_outputs: got key=%h press=%h rel=%h active=%b, want all 0",
                  bus.key, bus.press, bus.rel, bus.active);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_clean_press();
      logic [6:0] ek, ep;
      bus.key_raw = 7'h01;
      for (int k = 0; k < LAT + 3; k++) begin
         tick();
         ek = (k >= LAT) ? 7'h01 : 7'h00;
         ep = (k == LAT) ? 7'h01 : 7'h00;
         total++;
         if (bus.key !== ek) begin
            bad++;
            $display("FAIL press_key edge%0d: got %b want %b", k, bus.key, ek);
         end
         total++;
         if (bus.press !== ep) begin
            bad++;
            $display("FAIL press_pulse edge%0d: got %b want %b", k, bus.press, ep);
         end
         total++;
         if (bus.active !== (k >= LAT)) begin
            bad++;
            $display("FAIL press_active edge%0d: got %b want %b", k, bus.active, k >= LAT);
         end
      end
      bus.key_raw = 7'h00;
      idle(LAT + 2);
   endtask

   task automatic test_bounce();
      int presses;
      logic [6:0] ek;
      presses = 0;
      bus.key_raw = 7'h00;
      for (int t = 0; t < 10; t++) begin
         bus.key_raw[3] = ~bus.key_raw[3];
         for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if (bus.key !== 7'h00 || bus.press !== 7'h00) begin
               bad++;
               $display("FAIL bounce_reject t%0d: got key=%b press=%b want 0", t, bus.key, bus.press);
            end
         end
      end
      bus.key_raw[3] = 1'b1;
      for (int k = 0; k < LAT + 4; k++) begin
         tick();
         if (bus.press[3]) presses++;
         ek = (k >= LAT) ? 7'h08 : 7'h00;
         total++;
         if (bus.key !== ek) begin
            bad++;
            $display("FAIL bounce_settle edge%0d: got %b want %b", k, bus.key, ek);
         end
      end
      total++;
      if (presses !== 1) begin
         bad++;
         $display("FAIL bounce_press_count: got %0d want 1", presses);
      end
      bus.key_raw = 7'h00;
      idle(LAT + 2);
   endtask

   task automatic test_release();
      logic [6:0] ek, er;
      bus.key_raw = 7'h40;
      idle(LAT + 2);
      total++;
      if (bus.key !== 7'h40) begin
         bad++;
         $display("FAIL release_setup: got %b want %b", bus.key, 7'h40);
      end
      bus.key_raw = 7'h00;
      for (int k = 0; k < LAT + 3; k++) begin
         tick();
         ek = (k >= LAT) ? 7'h00 : 7'h40;
         er = (k == LAT) ? 7'h40 : 7'h00;
         total++;
         if (bus.key !== ek) begin
            bad++;
            $display("FAIL release_key edge%0d: got %b want %b", k, bus.key, ek);
         end
         total++;
         if (bus.rel !== er) begin
            bad++;
            $display("FAIL release_pulse edge%0d: got %b want %b", k, bus.rel, er);
         end
         total++;
         if (bus.active !== (k < LAT)) begin
            bad++;
            $display("FAIL release_active edge%0d: got %b want %b", k, bus.active, k < LAT);
         end
      end
   endtask

   task automatic test_reset_midcount();
      logic [6:0] ek, ep;
      bus.key_raw = 7'h04;
      idle(3);
      rst_n = 1'b0;
      #1;
      for (int c = 0; c < 2; c++) begin
         total++;
         if ({bus.key, bus.press, bus.rel, bus.active} !== 22'h0) begin
            bad++;
            $display("FAIL midreset_outputs c%0d: got key=%h press=%h rel=%h active=%b, want all 0",
                     c, bus.key, bus.press, bus.rel, bus.active);
         end
         tick();
      end
      rst_n = 1'b1;
      for (int k = 0; k < LAT + 3; k++) begin
         tick();
         ek = (k >= LAT) ? 7'h04 : 7'h00;
         ep = (k == LAT) ? 7'h04 : 7'h00;
         total++;
         if (bus.key !== ek) begin
            bad++;
            $display("FAIL midreset_key edge%0d: got %b want %b", k, bus.key, ek);
         end
         total++;
         if (bus.press !== ep) begin
            bad++;
            $display("FAIL midreset_press edge%0d: got %b want %b", k, bus.press, ep);
         end
      end
      bus.key_raw = 7'h00;
      idle(LAT + 2);
   endtask

   task automatic test_chord();
      logic [6:0] ek, ep, er;
      bus.key_raw = 7'h04;
      idle(10);
      total++;
      if (bus.key !== 7'h04) begin
         bad++;
         $display("FAIL chord_first: got %b want %b", bus.key, 7'h04);
      end
      bus.key_raw = 7'h24;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (ONEHOT) begin
            ek = 7'h04;
            ep = 7'h00;
         end else begin
            ek = (k >= LAT) ? 7'h24 : 7'h04;
            ep = (k == LAT) ? 7'h20 : 7'h00;
         end
         total++;
         if (bus.key !== ek || bus.press !== ep) begin
            bad++;
            $display("FAIL chord_second edge%0d: got key=%b press=%b want key=%b press=%b",
                     k, bus.key, bus.press, ek, ep);
         end
      end
      bus.key_raw = 7'h20;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (ONEHOT) begin
            ek = (k < DB + 2) ? 7'h04 : (k == DB + 2) ? 7'h00 : 7'h20;
            ep = (k == DB + 3) ? 7'h20 : 7'h00;
            er = (k == DB + 2) ? 7'h04 : 7'h00;
         end else begin
            ek = (k >= DB + 1) ? 7'h20 : 7'h24;
            ep = 7'h00;
            er = (k == DB + 1) ? 7'h04 : 7'h00;
         end
         total++;
         if (bus.key !== ek || bus.press !== ep || bus.rel !== er) begin
            bad++;
            $display("FAIL chord_handover edge%0d: got key=%b press=%b rel=%b want key=%b press=%b rel=%b",
                     k, bus.key, bus.press, bus.rel, ek, ep, er);
         end
      end
      bus.key_raw = 7'h00;
      idle(LAT + 3);
      total++;
      if (bus.key !== 7'h00 || bus.active !== 1'b0) begin
         bad++;
         $display("FAIL chord_clear: got key=%b active=%b want 0", bus.key, bus.active);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.key_raw = 7'h00;
      test_reset();
      test_clean_press();
      test_bounce();
      test_release();
      test_reset_midcount();
      test_chord();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/key_debounce.md
# key_debounce

Front-end conditioning stage for the seven note buttons. It synchronises the raw button inputs to `clk`, debounces each bit with its own counter, and produces a clean key vector plus single-cycle press/release pulses. The key vector feeds the free-mode keyboard decoder, whose `{pitch, key}` decode expects a stable, ideally one-hot, 7-bit key vector (bit 0 = do … bit 6 = si).

## Interface

**Parameters**
- `DB_CYCLES`, default 2_000_000: consecutive cycles (20 ms at 100 MHz) that the synchronised input must differ from the debounced state before the debounced state flips. Legal range is ≥ 1.
- `CW`, default `$clog2(DB_CYCLES)`: per-key counter width. It is derived and is not overridden.

**Ports**
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_raw`  in  7  raw button levels, asynchronous, 1 = pressed.
- `key`  out  7  debounced (and optionally arbitrated) key vector, 1 = held.
- `press`  out  7  one-cycle pulse on the `key[i]` 0→1 transition.
- `release`  out  7  one-cycle pulse on the `key[i]` 1→0 transition.
- `active`  out  1  `|key`.

## Operation

- **Synchroniser**
  - Two flops per bit: `s1 <= key_raw`, `s2 <= s1`.
- **Debounce, per bit i**
  - Each bit has a `stable[i]` state and a `cnt[i]` counter of width `CW`.
  - Each edge, if `s2[i] == stable[i]`, then `cnt[i] <= 0`. Any agreeing cycle fully restarts the count.
  - Otherwise, if `cnt[i] == DB_CYCLES-1`, then `stable[i] <= s2[i]` and `cnt[i] <= 0`.
  - Otherwise `cnt[i] <= cnt[i]+1`.
  - Counters never wrap. They are bounded by `DB_CYCLES-1`.
- **Output stage**
  - `key` is derived from `stable` (see Configuration).
  - `press` is registered as `key_next & ~key`. `release` is registered as `~key_next & key`.
  - Both are registered on the same edge as `key`, so each pulse is high for exactly the first cycle of the new `key` value.
  - `active` is combinational from `key`.
- **Multiple keys**
  - Bits are independent in the debounce stage. Simultaneous changes on different bits produce simultaneous pulses.
- **Reset (`rst_n` low, any time, including mid-count)**
  - Clears `s1`, `s2`, `stable`, all `cnt`, `key`, `press`, `release` and the owner register immediately.
  - Outputs are all 0 while reset is asserted.
  - After release, a held button is re-debounced from a count of 0. It produces a fresh `press`.

## Timing

- Edge numbering: `key_raw` changes and meets setup before edge 0, then holds.
  - `s2` shows the new value after edge 1.
  - `stable` flips at edge `DB_CYCLES+1`.
- Without `KEY_ONEHOT_EN`:
  - `key` and the pulse change at edge `DB_CYCLES+1`.
  - Total latency is `DB_CYCLES+1` edges.
- With `KEY_ONEHOT_EN`: one extra edge, so `DB_CYCLES+2`.
- Glitch rejection: any input excursion shorter than `DB_CYCLES` synchronised cycles never reaches `key`.
- Pulse width is always exactly 1 cycle. Back-to-back press and release of the same bit are separated by at least `DB_CYCLES` cycles.

## Configuration

Macro `KEY_ONEHOT_EN`.

**Defined: single-owner arbitration.**
- A 7-bit owner register drives `key`.
- If the owner is 0 and `stable != 0`, the owner takes the lowest-indexed set bit of `stable`.
- If the owner's bit clears in `stable`, the owner goes to 0 on that edge. Re-arbitration among the still-held keys happens on the following edge.
- While the owner is non-zero, other stable keys are ignored and produce no pulses.
- `key` is therefore always 0 or one-hot.

**Undefined:**
- `key = stable` directly, with no owner register and no extra latency.
- Chords appear as multi-hot vectors, which the downstream decoder treats as silence.

## Test plan

All cases use `DB_CYCLES=4`.
- **Clean press:** `key_raw=7'b0000001` set before edge 0 and held.
  - `key=0000001` after edge 5 (edge 6 with macro).
  - `press[0]` high for exactly 1 cycle.
  - `active=1`.
- **Bounce rejection:** `key_raw[3]` toggles every 2 cycles for 20 cycles, then stays 1.
  - `key[3]` stays 0 throughout the bounce.
  - `key[3]` rises exactly `DB_CYCLES+1` edges (or `+2` with macro) after the last toggle.
  - One `press[3]` pulse only.
- **Release:** with `key[6]=1`, drop `key_raw[6]` to 0.
  - `key[6]` falls at the same latency.
  - `release[6]` is 1 cycle wide.
  - `active` returns to 0.
- **Reset mid-count:** raise `key_raw[2]`, then assert `rst_n=0` at edge 3 for 2 cycles, then deassert.
  - All outputs are 0 during reset.
  - `key[2]` rises `DB_CYCLES+1` (`+2`) edges after the first post-reset edge.
- **Chord, with macro:** press bit 2, then 10 cycles later bit 5, then release bit 2.
  - `key` goes `0000100` → `0000000` for 1 cycle → `0100000`.
  - `press[5]` fires only at the hand-over.
- **Chord, without macro:** same stimulus.
  - `key` goes `0000100` → `0100100` → `0100000`.
  - `press[5]` fires on the second key's debounce.
